// File: rtl/sentinel_pkg.sv
// Shared types and status codes for the multi-symbol sentinel lock.
package sentinel_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_VERIFIED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  localparam logic [7:0] STATUS_LOCKED   = 8'h3F;
  localparam logic [7:0] STATUS_VERIFIED = 8'hC1;
  localparam logic [7:0] STATUS_LOCKOUT  = 8'hEE;

  function automatic logic [7:0] status_of(state_t s);
    case (s)
      ST_VERIFIED: status_of = STATUS_VERIFIED;
      ST_LOCKOUT:  status_of = STATUS_LOCKOUT;
      default:     status_of = STATUS_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/sentinel_lockout_timer.sv
// Loadable down-counter that times the lockout window; expired means count is zero.
module sentinel_lockout_timer #(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= TW'(LOCKOUT_CYCLES - 1);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/sentinel_seq_lock.sv
// Multi-symbol sequence lock: LOCKED -> VERIFIED on the full key in order,
// LOCKED -> LOCKOUT after MAX_FAILS consecutive mismatches.
module sentinel_seq_lock
  import sentinel_pkg::*;
#(
  parameter int KEY_WIDTH      = 8,
  parameter int KEY_LEN        = 4,
  parameter logic [KEY_LEN*KEY_WIDTH-1:0] KEY = 32'h5AA53CB6,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic                             in_valid,
  input  logic [KEY_WIDTH-1:0]             in_data,
  input  logic                             relock,
  output logic [7:0]                       status_out,
  output logic                             verified,
  output logic                             lockout,
  output logic [$clog2(KEY_LEN+1)-1:0]     progress,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int PW = $clog2(KEY_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  // Handshake: in_valid has no ready; with ena high every in_valid symbol is
  // consumed on that edge, and with ena low it is dropped entirely.
  state_t          state_q, state_d;
  logic [PW-1:0]   progress_q, progress_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [FW-1:0]   fail_inc;
  logic [KEY_WIDTH-1:0] key_sym;
  logic            timer_load;
  logic            timer_en;
  logic            timer_expired;

  always_comb begin
    key_sym = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (progress_q == PW'(i)) key_sym = KEY[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    fail_d     = fail_q;
    timer_load = 1'b0;
    if (ena) begin
      case (state_q)
        ST_LOCKED: begin
          if (relock) begin
            progress_d = '0;
          end else if (in_valid) begin
            if (in_data == key_sym) begin
              if (progress_q == PW'(KEY_LEN - 1)) begin
                state_d    = ST_VERIFIED;
                progress_d = '0;
                fail_d     = '0;
              end else begin
                progress_d = progress_q + PW'(1);
              end
            end else begin
              // A mismatch is discarded, not retried as the first symbol.
              progress_d = '0;
              if (fail_inc == FW'(MAX_FAILS)) begin
                state_d    = ST_LOCKOUT;
                fail_d     = '0;
                timer_load = 1'b1;
              end else begin
                fail_d = fail_inc;
              end
            end
          end
        end
        ST_VERIFIED: begin
          if (relock) state_d = ST_LOCKED;
        end
        ST_LOCKOUT: begin
          if (timer_expired) state_d = ST_LOCKED;
        end
        default: begin
          state_d    = ST_LOCKED;
          progress_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKED;
      progress_q <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      fail_q     <= fail_d;
    end
  end

  assign timer_en = ena && (state_q == ST_LOCKOUT);

  sentinel_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );

  assign status_out = status_of(state_q);
  assign verified   = (state_q == ST_VERIFIED);
  assign lockout    = (state_q == ST_LOCKOUT);
  assign progress   = progress_q;
  assign fail_count = fail_q;

endmodule

// File: doc/sentinel_seq_lock.md
# sentinel_seq_lock

Parametrised multi-symbol sentinel lock, successor to the single-key Sentinel. It accepts a keyed sequence of `KEY_LEN` symbols of `KEY_WIDTH` bits and reports VERIFIED only after the full sequence is entered in order. Repeated failures trigger a timed lockout. It sits behind the `ui_in` pad decode and drives the `uo_out` status byte of the Tiny Tapeout wrapper.

## Interface
- `KEY_WIDTH`, default 8: symbol width in bits.
- `KEY_LEN`, default 4: number of symbols in the key; must be ≥1.
- `KEY`, default 32'h5A_A5_3C_B6: packed key, `KEY_LEN*KEY_WIDTH` bits.
  - Symbol i is `KEY[i*KEY_WIDTH +: KEY_WIDTH]`.
  - Symbol 0 is the LSBs, so the default entry order is B6, 3C, A5, 5A.
- `MAX_FAILS`, default 3: consecutive mismatches that trigger lockout; must be ≥1.
- `LOCKOUT_CYCLES`, default 16: lockout duration in enabled cycles; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable; when low, all state is frozen and all inputs are ignored.
- `in_valid`  in  1  `in_data` carries a symbol this cycle.
- `in_data`  in  `KEY_WIDTH`  candidate key symbol.
- `relock`  in  1  return from VERIFIED to LOCKED, or abort a partial entry.
- `status_out`  out  8  status code: LOCKED 8'h3F, VERIFIED 8'hC1, LOCKOUT 8'hEE.
- `verified`  out  1  high exactly when the state is VERIFIED.
- `lockout`  out  1  high exactly when the state is LOCKOUT.
- `progress`  out  `$clog2(KEY_LEN+1)`  count of correct symbols accepted in the current attempt.
- `fail_count`  out  `$clog2(MAX_FAILS+1)`  consecutive mismatches since the last clear.

## Operation
- There are three states: LOCKED, VERIFIED and LOCKOUT. All outputs are registered or decoded directly from registered state.
- Reset values:
  - State is LOCKED.
  - `status_out` = 8'h3F.
  - `verified`, `lockout`, `progress` and `fail_count` are 0.
  - The lockout timer is 0.
- In LOCKED, a symbol is accepted when `ena && in_valid`:
  - **Match** (`in_data == KEY` symbol[`progress`]):
    - If `progress == KEY_LEN-1`, go to VERIFIED, clear `progress` and clear `fail_count`.
    - Otherwise increment `progress`.
  - **Mismatch**:
    - Clear `progress` and discard the symbol. The mismatching symbol is never re-evaluated as symbol 0.
    - Increment `fail_count`.
    - If the incremented value equals `MAX_FAILS`, go to LOCKOUT, load the timer with `LOCKOUT_CYCLES-1`, and clear `fail_count`.
- `relock` in LOCKED clears `progress`; `fail_count` is unchanged. If `relock` and `in_valid` arrive in the same cycle, `relock` wins and the symbol is discarded (it counts as neither a match nor a mismatch).
- In VERIFIED, `in_valid` is ignored. `relock` moves the state to LOCKED. VERIFIED otherwise persists indefinitely.
- In LOCKOUT:
  - `in_valid` and `relock` are ignored.
  - The timer decrements every cycle with `ena` high.
  - When the timer is 0 and `ena` is high, go to LOCKED.
- `KEY_LEN == 1`: a single matching symbol goes directly to VERIFIED.
- Security invariant: VERIFIED is entered only on the edge that accepts a matching final key symbol while in LOCKED.

## Timing
- VERIFIED latency: `status_out` = 8'hC1 and `verified` = 1 in the cycle after the edge that accepts symbol `KEY_LEN-1`.
- LOCKOUT entry: `status_out` = 8'hEE in the cycle after the edge that accepts the `MAX_FAILS`-th mismatch.
- LOCKOUT duration: the state holds for exactly `LOCKOUT_CYCLES` enabled cycles, then returns to LOCKED. Cycles with `ena` low extend the lockout.
- `relock` takes effect on the next edge; `status_out` returns to 8'h3F one cycle later.
- Asynchronous reset mid-operation forces reset values immediately, including a partial entry and an active lockout. Deassertion is handled by the wrapper's synchroniser; this block does not re-synchronise `rst_n`.
- There is no backpressure. Every enabled `in_valid` symbol is consumed in one cycle.

## Structure
- Package `sentinel_pkg` holds:
  - The state enum (LOCKED, VERIFIED, LOCKOUT).
  - Status code localparams: `STATUS_LOCKED`, `STATUS_VERIFIED`, `STATUS_LOCKOUT`.
- Sub-module `sentinel_lockout_timer`:
  - Loadable down-counter, width `$clog2(LOCKOUT_CYCLES)` (minimum 1).
  - Inputs: `load`, `en`.
  - Output: `expired` (count == 0).
- Top level holds the state register, the `progress` and `fail_count` registers, and the key symbol mux.
- The formal checker binds to this block and asserts the security invariant, generalised to the last `KEY_LEN` accepted symbols.

## Test plan
1. Reset, then valid symbols B6, 3C, A5, 5A on consecutive cycles → `progress` steps 1, 2, 3; `status_out` = C1 one cycle after 5A; `fail_count` = 0.
2. B6, 3C, then 00 → `progress` = 0 and `fail_count` = 1. Then B6, 3C, A5, 5A → VERIFIED and `fail_count` = 0.
3. Three wrong symbols (11, 22, 33) → EE after the third. Hold `ena` high for 16 cycles → 3F on the 17th; `fail_count` = 0. B6 during lockout is ignored.
4. In LOCKED mid-entry, assert `relock` together with `in_valid` = A5 → `progress` = 0 and `fail_count` unchanged. In VERIFIED, `relock` → 3F next cycle.
5. During lockout, drop `ena` for 5 cycles → lockout lasts 21 cycles total. With `ena` low in LOCKED, B6 is ignored.
6. Assert `rst_n` low asynchronously mid-lockout and mid-entry → all outputs at reset values before the next clock edge.
